atm_transaction_ctrl: RTL
=========================

# atm_transaction_ctrl

Session and transaction controller directly downstream of `cardhandling`. It tracks card insertion and password verification, with three attempts before the card is retained. It executes balance-inquiry, withdraw and deposit requests against the `balance` that `cardhandling` presents, and returns `updated_balance` plus a one-cycle `op_done` write-back strobe to `cardhandling`.

## Interface
- `balance_width`, 20, width of balance/amount words
- `max_attempts`, 3, wrong-password tries before card retention (1..7)
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `card_in`  in  1  level, card present in slot
- `psw_valid`  in  1  pulse, user has applied `password_input` to `cardhandling` this cycle
- `wrong_psw`  in  1  from `cardhandling`, valid the cycle after `psw_valid`
- `balance`  in  `balance_width`  current account balance from `cardhandling`
- `op_valid`  in  1  transaction request
- `op_code`  in  2  00 inquiry, 01 withdraw, 10 deposit, 11 exit
- `amount`  in  `balance_width`  transaction amount, unsigned
- `op_ready`  out  1  controller accepts `op_valid` this cycle
- `op_done`  out  1  one-cycle write-back strobe to `cardhandling`
- `updated_balance`  out  `balance_width`  new balance, valid with `op_done`
- `shown_balance`  out  `balance_width`  registered balance for display
- `insufficient_funds`  out  1  one-cycle error pulse
- `deposit_overflow`  out  1  one-cycle error pulse
- `card_retained`  out  1  level, card swallowed
- `card_eject`  out  1  one-cycle eject pulse

## Operation
- FSM states: IDLE, WAIT_PSW, CHECK_PSW, READY, EXEC, RETAIN, EJECT.
- IDLE: on `card_in`=1, go to WAIT_PSW and clear the attempt counter.
- WAIT_PSW: on `psw_valid`, go to CHECK_PSW.
- CHECK_PSW (one cycle), samples `wrong_psw`:
  - 0: go to READY.
  - 1 and the incremented count equals `max_attempts`: go to RETAIN.
  - 1 otherwise: increment the counter and return to WAIT_PSW.
- READY: `op_ready`=1. A request is accepted when `op_valid`=1. `op_code` and `amount` are latched and the FSM goes to EXEC. `op_code`=11 goes to EJECT instead.
- EXEC (one cycle), then returns to READY:
  - Inquiry: `shown_balance`←`balance`. No `op_done`.
  - Withdraw: if `amount` > `balance`, pulse `insufficient_funds` and leave the balance unchanged. Otherwise `updated_balance`←`balance`−`amount`, `op_done`=1, `shown_balance`←result.
  - Deposit: compute `balance`+`amount` at `balance_width`+1 bits. If the carry bit is set, pulse `deposit_overflow` and write nothing. Otherwise `updated_balance`←sum, `op_done`=1, `shown_balance`←sum.
  - `amount`=0 is legal: write-back of the unchanged balance with `op_done`=1.
- EJECT: pulse `card_eject` for one cycle, then go to IDLE.
- RETAIN: `card_retained`=1 and held. Exit only on `rst`. `card_in` is ignored.
- `card_in` falling in WAIT_PSW, CHECK_PSW, READY or EXEC aborts the session and returns to IDLE next cycle. No `op_done` is issued in the abort cycle, and `card_eject` is not pulsed.
- `op_valid` outside READY is ignored and is not queued.

## Timing
- Reset values: state IDLE, all outputs 0, counter 0.
- Card to ready: `psw_valid` at cycle t, CHECK_PSW at t+1, `op_ready`=1 at t+2.
- Accept to write-back: request accepted at cycle t, `op_done`/error pulse registered at t+1, `op_ready` high again at t+2.
- `updated_balance` holds its value after `op_done`. `shown_balance` holds until the next inquiry, successful transaction or reset.
- `rst` during EXEC suppresses `op_done` that cycle.

## Structure
- `atm_pkg` holds:
  - the `op_code` enum (OP_INQ, OP_WDR, OP_DEP, OP_EXIT);
  - the FSM state enum;
  - `BALANCE_WIDTH` and `MAX_ATTEMPTS` defaults, shared with `cardhandling`.
- One sub-module, `psw_attempt_counter`:
  - saturating counter with clear, increment, and `limit_hit` output.
- Arithmetic and the FSM live in the top module.

## Test plan
- Card in, one `psw_valid` with `wrong_psw`=0 → `op_ready`=1 two cycles later; `card_retained`=0.
- Three `psw_valid` with `wrong_psw`=1 → after the third, `card_retained`=1 and stays 1 until `rst`; a fourth `psw_valid` has no effect.
- `balance`=1000, withdraw 300 → `op_done`=1 for one cycle, `updated_balance`=700. Withdraw 1001 → `insufficient_funds`=1, no `op_done`.
- `balance`=20'hFFFF0, deposit 20'h10 → `deposit_overflow`=1, no `op_done`. Deposit 20'hF → `updated_balance`=20'hFFFFF, `op_done`=1.
- Inquiry with `balance`=1234 → `shown_balance`=1234, `op_done`=0. Then exit → `card_eject` one-cycle pulse, state IDLE.
- `card_in` dropped in the EXEC cycle, or `rst` asserted in EXEC → no `op_done`; all outputs at reset values after `rst`.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM session/transaction controller.
// Also used by cardhandling so both sides agree on widths and encodings.
package atm_pkg;

  localparam int BALANCE_WIDTH = 20;
  localparam int MAX_ATTEMPTS  = 3;

  typedef enum logic [1:0] {
    OP_INQ  = 2'b00,
    OP_WDR  = 2'b01,
    OP_DEP  = 2'b10,
    OP_EXIT = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PSW,
    S_CHECK_PSW,
    S_READY,
    S_EXEC,
    S_RETAIN,
    S_EJECT
  } state_t;

endpackage

// File: rtl/psw_attempt_counter.sv
// Saturating wrong-password attempt counter.
// limit_hit flags that one more increment reaches max_attempts.
module psw_attempt_counter #(
  parameter int max_attempts = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  localparam logic [2:0] MAX = 3'(max_attempts);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != MAX)
      cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign limit_hit = (cnt_q == MAX - 3'd1);

endmodule

// File: rtl/atm_transaction_ctrl.sv
// ATM session FSM: card/password handling, retention, and
// inquiry/withdraw/deposit execution with registered outputs.
module atm_transaction_ctrl
  import atm_pkg::*;
#(
  parameter int balance_width = BALANCE_WIDTH,
  parameter int max_attempts  = MAX_ATTEMPTS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     psw_valid,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  output logic                     op_ready,
  output logic                     op_done,
  output logic [balance_width-1:0] updated_balance,
  output logic [balance_width-1:0] shown_balance,
  output logic                     insufficient_funds,
  output logic                     deposit_overflow,
  output logic                     card_retained,
  output logic                     card_eject
);

  localparam int W = balance_width;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [W-1:0]   amt_q, amt_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic [W-1:0]   upd_q, upd_d;
  logic [W-1:0]   shown_q, shown_d;
  logic           insuf_q, insuf_d;
  logic           ovf_q, ovf_d;
  logic           ret_q, ret_d;
  logic           ej_q, ej_d;

  logic           cnt_clr;
  logic           cnt_inc;
  logic           limit_hit;
  logic [W:0]     sum;

  psw_attempt_counter #(
    .max_attempts(max_attempts)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .limit_hit(limit_hit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    amt_d   = amt_q;
    done_d  = 1'b0;
    upd_d   = upd_q;
    shown_d = shown_q;
    insuf_d = 1'b0;
    ovf_d   = 1'b0;
    ret_d   = ret_q;
    ej_d    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    sum     = {1'b0, balance} + {1'b0, amt_q};

    unique case (state_q)
      S_IDLE: begin
        if (card_in) begin
          state_d = S_WAIT_PSW;
          cnt_clr = 1'b1;
        end
      end
      S_WAIT_PSW: begin
        if (!card_in)
          state_d = S_IDLE;
        else if (psw_valid)
          state_d = S_CHECK_PSW;
      end
      S_CHECK_PSW: begin
        if (!card_in)
          state_d = S_IDLE;
        else if (!wrong_psw)
          state_d = S_READY;
        else begin
          cnt_inc = 1'b1;
          if (limit_hit) begin
            state_d = S_RETAIN;
            ret_d   = 1'b1;
          end else begin
            state_d = S_WAIT_PSW;
          end
        end
      end
      S_READY: begin
        if (!card_in)
          state_d = S_IDLE;
        else if (op_valid) begin
          if (op_t'(op_code) == OP_EXIT) begin
            state_d = S_EJECT;
            ej_d    = 1'b1;
          end else begin
            state_d = S_EXEC;
            op_d    = op_t'(op_code);
            amt_d   = amount;
          end
        end
      end
      S_EXEC: begin
        if (!card_in)
          state_d = S_IDLE;
        else begin
          state_d = S_READY;
          unique case (op_q)
            OP_WDR: begin
              if (amt_q > balance)
                insuf_d = 1'b1;
              else begin
                upd_d   = balance - amt_q;
                shown_d = balance - amt_q;
                done_d  = 1'b1;
              end
            end
            OP_DEP: begin
              // carry out of the widened sum means the account would wrap
              if (sum[W])
                ovf_d = 1'b1;
              else begin
                upd_d   = sum[W-1:0];
                shown_d = sum[W-1:0];
                done_d  = 1'b1;
              end
            end
            OP_INQ:  shown_d = balance;
            default: ;
          endcase
        end
      end
      S_RETAIN: ret_d = 1'b1;
      S_EJECT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_INQ;
      amt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      upd_q   <= '0;
      shown_q <= '0;
      insuf_q <= 1'b0;
      ovf_q   <= 1'b0;
      ret_q   <= 1'b0;
      ej_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      upd_q   <= upd_d;
      shown_q <= shown_d;
      insuf_q <= insuf_d;
      ovf_q   <= ovf_d;
      ret_q   <= ret_d;
      ej_q    <= ej_d;
    end
  end

  assign op_ready           = ready_q;
  assign op_done            = done_q;
  assign updated_balance    = upd_q;
  assign shown_balance      = shown_q;
  assign insufficient_funds = insuf_q;
  assign deposit_overflow   = ovf_q;
  assign card_retained      = ret_q;
  assign card_eject         = ej_q;

endmodule
